hp0_stream_writer: RTL and testbench
====================================

Name: hp0_stream_writer

Overview:
AXI3 burst write master that drives the PS S_AXI_HP0 slave port from the PL side.
- Accepts a 32-bit valid/ready word stream and buffers it in a local FIFO.
- Writes the buffered words as INCR bursts into a circular DDR buffer.
- Reports the committed word count so PS software can consume the data.
- Sits between PL data sources (GMII capture, test generators) and the HP0 port of the PS wrapper.

Parameters:
BASE_ADDR, 32'h1000_0000, byte base of the ring buffer; must be 4 KB aligned.
BUF_WORDS, 65536, ring size in 32-bit words; power of 2, at least 16.
BURST_LEN, 16, maximum beats per burst; must be 16 (AXI3 limit; one burst = 64 bytes).
FIFO_DEPTH, 64, input FIFO depth in words; power of 2, at least 2*BURST_LEN.
AXI_ID, 6'd0, value driven on awid and wid.

Ports:
ACLK  in  1  single clock for all logic, including the HP0 interface.
ARESETN  in  1  asynchronous active-low reset.
enable  in  1  permits new bursts to start.
s_data  in  32  stream word.
s_valid  in  1  s_data is valid.
s_ready  out  1  FIFO can accept a word; deasserted when the FIFO is full.
wr_ptr  out  32  free-running count of words acknowledged by B responses.
err  out  1  sticky flag; set by any non-OKAY bresp.
busy  out  1  FSM is not in IDLE.
M_AXI_awaddr/awlen/awsize/awburst/awcache/awprot/awqos/awlock/awid/awvalid  out  32/4/3/2/4/3/4/2/6/1  AXI3 write address channel.
M_AXI_awready  in  1  AXI3 write address ready.
M_AXI_wdata/wstrb/wlast/wid/wvalid  out  32/4/1/6/1  AXI3 write data channel.
M_AXI_wready  in  1  AXI3 write data ready.
M_AXI_bid/bresp/bvalid  in  6/2/1  AXI3 write response channel.
M_AXI_bready  out  1  AXI3 write response ready.
This block has no read channel; the HP0 read signals are tied off at the top level.

Behaviour:
- Reset (asynchronous, while ARESETN=0):
  - awvalid, wvalid, bready, wlast, busy and err are 0; wr_ptr is 0.
  - The address pointer returns to BASE_ADDR and the FIFO is emptied.
  - s_ready is 0 while ARESETN=0 and 1 in the first cycle after release.
  - Reset mid-burst abandons the burst with no further handshakes.
- Fixed fields: awsize=3'b010, awburst=2'b01 (INCR), awcache=4'b0011, awprot=0, awqos=0, awlock=0, wstrb=4'hF, awid=wid=AXI_ID.
- Input: a word is pushed when s_valid && s_ready, with no loss and no reordering. Backpressure is the only response to a full FIFO.
- Burst length L = min(BURST_LEN, (64 - addr[5:0])/4). No burst crosses a 64 B boundary, so no burst crosses a 4 KB boundary.
- FSM states: IDLE, ADDR, DATA, RESP.
  - IDLE -> ADDR when enable=1 && fill >= L. awaddr and awlen=L-1 are latched and awvalid is raised in the same edge.
  - ADDR: awvalid is held with its fields stable until awready. -> DATA on the awvalid && awready cycle.
  - DATA: wvalid=1 while the FIFO is non-empty (always true, since L words are reserved). A word is popped on each wvalid && wready. wlast=1 on beat L-1. -> RESP after the last beat handshake.
  - RESP: bready=1. On bvalid, wr_ptr += L, and err is set if bresp != 2'b00. Address advances by L*4 and wraps to BASE_ADDR at BASE_ADDR + BUF_WORDS*4. -> IDLE.
- Latency: the first awvalid appears 1 cycle after fill reaches L. W is never issued before the AW handshake. Only one burst is outstanding.
- enable dropped mid-burst: the current burst completes through RESP, then the FSM stays in IDLE. Buffered words are retained.
- Simultaneous push and pop in the same cycle: fill is unchanged.
- wr_ptr advances even when a response is an error; software inspects err.
- busy = (state != IDLE).

Optional Feature:
HP0_WR_FLUSH_EN
- Defined:
  - Adds input port flush (1 bit, single-cycle pulse).
  - A flush in IDLE with 0 < fill < L issues one burst of fill beats (awlen = fill-1).
  - A flush while not in IDLE is held pending and takes effect on return to IDLE.
  - A flush with fill=0 is dropped.
  - The subsequent L formula realigns the address to a 64 B boundary.
- Undefined: the flush port is absent, only bursts of L beats are issued, and partial data waits in the FIFO.

Decomposition:
- Package hp0_axi_pkg:
  - burst/size/cache encodings.
  - OKAY response code.
  - FSM state enumeration.
  - 64 B burst-window constant.
- Sub-module hp0_wr_fifo: synchronous FIFO with parameterised depth and width 32, fill count output, and first-word-fall-through read.

Test Plan:
1. enable=1, push 32 words 0..31 -> two bursts at 0x1000_0000 and 0x1000_0040 with awlen=15 and data in order; wr_ptr=32; err=0.
2. BUF_WORDS=64, push 80 words -> fifth burst awaddr=0x1000_0000; wr_ptr=80.
3. awready delayed 10 cycles and wready toggling every other cycle -> AW fields stable while waiting, no beats lost or duplicated, wlast only on beat 15.
4. bresp=2'b10 on the second burst -> err=1 and stays 1; wr_ptr still reaches 32.
5. enable=0, push 64 words -> s_ready=0 after word 64 while s_valid is held; enable=1 -> all 64 words written in order.
6. With HP0_WR_FLUSH_EN: push 5 words, then flush -> awlen=4; push 16 more -> next burst at 0x1000_0014 with awlen=10. ARESETN low mid-DATA -> awvalid, wvalid and bready are 0 immediately.

Source files
------------

// File: rtl/hp0_axi_pkg.sv
// Shared encodings for the HP0 stream writer: AXI3 write-channel field
// values, the 64-byte burst window and the writer FSM state type.
package hp0_axi_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned ID_W   = 6;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [3:0] AXI_CACHE_BUF  = 4'b0011;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  // Bursts never straddle this window, so they never straddle 4 KB either.
  localparam int unsigned BURST_WINDOW_BYTES = 64;
  localparam int unsigned WINDOW_WORDS       = BURST_WINDOW_BYTES / 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_RESP
  } wr_state_e;

endpackage

// File: rtl/hp0_stream_writer_if.sv
// AXI3 write-only bus between the stream writer (master) and the PS HP0
// slave port: AW, W and B channels. The read channel is not carried.
interface hp0_stream_writer_if;
  import hp0_axi_pkg::*;

  logic [ADDR_W-1:0] awaddr;
  logic [3:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic [3:0]        awcache;
  logic [2:0]        awprot;
  logic [3:0]        awqos;
  logic [1:0]        awlock;
  logic [ID_W-1:0]   awid;
  logic              awvalid;
  logic              awready;

  logic [DATA_W-1:0] wdata;
  logic [3:0]        wstrb;
  logic              wlast;
  logic [ID_W-1:0]   wid;
  logic              wvalid;
  logic              wready;

  logic [ID_W-1:0]   bid;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  modport master (
    output awaddr, awlen, awsize, awburst, awcache, awprot, awqos, awlock, awid, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wid, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  awaddr, awlen, awsize, awburst, awcache, awprot, awqos, awlock, awid, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wid, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );

endinterface

// File: rtl/hp0_wr_fifo.sv
// Synchronous first-word-fall-through FIFO, 32-bit words.
// Ports: clk, rst_n (async active-low), wr_en/wr_data (push, ignored when
// full), rd_en (pop, ignored when empty), rd_data (head word), fill (word
// count), full.
module hp0_wr_fifo #(
  parameter int unsigned DEPTH = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [31:0]                wr_data,
  input  logic                       rd_en,
  output logic [31:0]                rd_data,
  output logic [$clog2(DEPTH):0]     fill,
  output logic                       full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_idx_q;
  logic [AW-1:0] rd_idx_q;
  logic [CW-1:0] count_q;
  logic          push_c;
  logic          pop_c;

  assign full    = (count_q == CW'(DEPTH));
  assign push_c  = wr_en && !full;
  assign pop_c   = rd_en && (count_q != '0);
  assign rd_data = mem[rd_idx_q];
  assign fill    = count_q;

  // Storage carries no reset; only the indices and count define contents.
  always_ff @(posedge clk) begin
    if (push_c) mem[wr_idx_q] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_idx_q <= '0;
      rd_idx_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_c) wr_idx_q <= wr_idx_q + AW'(1);
      if (pop_c)  rd_idx_q <= rd_idx_q + AW'(1);
      case ({push_c, pop_c})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/hp0_stream_writer.sv
// AXI3 burst write master for the PS HP0 port. Buffers a 32-bit valid/ready
// stream and writes it as INCR bursts into a circular DDR buffer, counting
// acknowledged words in wr_ptr.
// Ports: ACLK, ARESETN (async active-low), enable (allows new bursts),
// s_data/s_valid/s_ready (input stream), wr_ptr (words acknowledged),
// err (sticky non-OKAY bresp), busy (FSM not idle), M_AXI (AXI3 write master).
// Build option HP0_WR_FLUSH_EN adds a flush pulse input that writes out a
// partial burst of whatever is buffered.
module hp0_stream_writer
  import hp0_axi_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
  parameter int unsigned BUF_WORDS  = 65536,
  parameter int unsigned BURST_LEN  = 16,
  parameter int unsigned FIFO_DEPTH = 64,
  parameter logic [5:0]  AXI_ID     = 6'd0
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  enable,
`ifdef HP0_WR_FLUSH_EN
  input  logic                  flush,
`endif
  input  logic [31:0]           s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [31:0]           wr_ptr,
  output logic                  err,
  output logic                  busy,
  hp0_stream_writer_if.master   M_AXI
);

  localparam int unsigned OFF_W  = $clog2(BUF_WORDS);
  localparam int unsigned FILL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned LEN_W  = 5;

  wr_state_e         state_q;
  logic [OFF_W-1:0]  off_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  beat_q;
  logic [31:0]       awaddr_q;
  logic [3:0]        awlen_q;
  logic              awvalid_q;
  logic              wvalid_q;
  logic              wlast_q;
  logic              bready_q;
  logic [31:0]       wr_ptr_q;
  logic              err_q;
  logic              live_q;

  logic [FILL_W-1:0] fill;
  logic              full;
  logic [31:0]       fifo_rd_data;
  logic [LEN_W-1:0]  room_c;
  logic [LEN_W-1:0]  burst_l_c;
  logic [LEN_W-1:0]  beats_c;
  logic              fill_ge_l_c;
  logic              go_c;
  logic              push_c;
  logic              pop_c;

  // Words left before the next 64 B boundary caps the burst length.
  assign room_c      = LEN_W'(WINDOW_WORDS) - {1'b0, off_q[3:0]};
  assign burst_l_c   = (room_c > LEN_W'(BURST_LEN)) ? LEN_W'(BURST_LEN) : room_c;
  assign fill_ge_l_c = (fill >= FILL_W'(burst_l_c));
  // Short count only reachable through a flush, where fill < burst_l_c <= 16.
  assign beats_c     = fill_ge_l_c ? burst_l_c : LEN_W'(fill);

`ifdef HP0_WR_FLUSH_EN
  logic flush_pend_q;
  logic flush_req_c;
  assign flush_req_c = flush | flush_pend_q;
  assign go_c        = (enable && fill_ge_l_c) || (flush_req_c && (fill != '0));
`else
  assign go_c        = enable && fill_ge_l_c;
`endif

  // s_ready stays low until the first clock after reset release.
  assign s_ready = live_q && !full;
  assign push_c  = s_valid && s_ready;
  assign pop_c   = wvalid_q && M_AXI.wready;

  hp0_wr_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (ACLK),
    .rst_n   (ARESETN),
    .wr_en   (push_c),
    .wr_data (s_data),
    .rd_en   (pop_c),
    .rd_data (fifo_rd_data),
    .fill    (fill),
    .full    (full)
  );

  // Burst sequencer: one outstanding burst, AW then W beats then B.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q   <= ST_IDLE;
      off_q     <= '0;
      len_q     <= '0;
      beat_q    <= '0;
      awaddr_q  <= BASE_ADDR;
      awlen_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      wlast_q   <= 1'b0;
      bready_q  <= 1'b0;
      wr_ptr_q  <= '0;
      err_q     <= 1'b0;
      live_q    <= 1'b0;
`ifdef HP0_WR_FLUSH_EN
      flush_pend_q <= 1'b0;
`endif
    end else begin
      live_q <= 1'b1;
`ifdef HP0_WR_FLUSH_EN
      // IDLE consumes the request this cycle; elsewhere it waits for IDLE.
      if (state_q == ST_IDLE) flush_pend_q <= 1'b0;
      else if (flush)         flush_pend_q <= 1'b1;
`endif
      case (state_q)
        ST_IDLE: begin
          if (go_c) begin
            awaddr_q  <= BASE_ADDR + 32'({off_q, 2'b00});
            awlen_q   <= 4'(beats_c - LEN_W'(1));
            len_q     <= beats_c;
            awvalid_q <= 1'b1;
            state_q   <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (M_AXI.awready) begin
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b1;
            wlast_q   <= (len_q == LEN_W'(1));
            beat_q    <= '0;
            state_q   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (M_AXI.wready) begin
            if (wlast_q) begin
              wvalid_q <= 1'b0;
              wlast_q  <= 1'b0;
              bready_q <= 1'b1;
              state_q  <= ST_RESP;
            end else begin
              beat_q  <= beat_q + LEN_W'(1);
              wlast_q <= (LEN_W'(beat_q + LEN_W'(2)) == len_q);
            end
          end
        end
        ST_RESP: begin
          if (M_AXI.bvalid) begin
            bready_q <= 1'b0;
            wr_ptr_q <= wr_ptr_q + 32'(len_q);
            if (M_AXI.bresp != AXI_RESP_OKAY) err_q <= 1'b1;
            // Offset register is exactly ring-sized, so it wraps to base.
            off_q    <= off_q + OFF_W'(len_q);
            state_q  <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign M_AXI.awaddr  = awaddr_q;
  assign M_AXI.awlen   = awlen_q;
  assign M_AXI.awsize  = AXI_SIZE_4B;
  assign M_AXI.awburst = AXI_BURST_INCR;
  assign M_AXI.awcache = AXI_CACHE_BUF;
  assign M_AXI.awprot  = 3'b000;
  assign M_AXI.awqos   = 4'b0000;
  assign M_AXI.awlock  = 2'b00;
  assign M_AXI.awid    = AXI_ID;
  assign M_AXI.awvalid = awvalid_q;
  assign M_AXI.wdata   = fifo_rd_data;
  assign M_AXI.wstrb   = 4'hF;
  assign M_AXI.wlast   = wlast_q;
  assign M_AXI.wid     = AXI_ID;
  assign M_AXI.wvalid  = wvalid_q;
  assign M_AXI.bready  = bready_q;

  assign wr_ptr = wr_ptr_q;
  assign err    = err_q;
  assign busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_hp0_stream_writer.sv
// Scoreboard bench for hp0_stream_writer (ring of 64 words at 0x1000_0000).
module tb_hp0_stream_writer;

  localparam logic [31:0] BASE = 32'h1000_0000;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] wr_ptr;
  logic        err;
  logic        busy;
`ifdef HP0_WR_FLUSH_EN
  logic        flush = 1'b0;
`endif

  hp0_stream_writer_if axi_if ();

  hp0_stream_writer #(
    .BUF_WORDS (64)
  ) dut (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .enable  (enable),
`ifdef HP0_WR_FLUSH_EN
    .flush   (flush),
`endif
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .wr_ptr  (wr_ptr),
    .err     (err),
    .busy    (busy),
    .M_AXI   (axi_if)
  );

  always #5 ACLK = ~ACLK;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] q_aw_addr [$];
  logic [3:0]  q_aw_len  [$];
  logic [31:0] q_w       [$];

  // Slave model configuration
  int aw_delay  = 0;
  bit w_toggle  = 1'b0;
  int err_burst = -1;

  // Slave model state
  int aw_wait   = 0;
  bit b_due     = 1'b0;
  int burst_no  = 0;
  bit wready_ph = 1'b0;

  // Monitor state
  bit          holding = 1'b0;
  logic [31:0] hold_addr = '0;
  logic [3:0]  hold_len = '0;
  bit          aw_done = 1'b0;
  int          beat = 0;
  logic [3:0]  cur_len = '0;
  logic [31:0] e_addr;
  logic [3:0]  e_len;
  logic [31:0] e_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
  endtask

  // AXI slave responder: drives at negedge, notes handshakes just after.
  initial begin
    axi_if.awready = 1'b0;
    axi_if.wready  = 1'b0;
    axi_if.bvalid  = 1'b0;
    axi_if.bresp   = 2'b00;
    axi_if.bid     = 6'd0;
    forever begin
      @(negedge ACLK);
      if (!ARESETN) begin
        axi_if.awready = 1'b0;
        axi_if.wready  = 1'b0;
        axi_if.bvalid  = 1'b0;
        axi_if.bresp   = 2'b00;
        aw_wait = 0; b_due = 1'b0; burst_no = 0; wready_ph = 1'b0;
      end else begin
        axi_if.awready = axi_if.awvalid && (aw_wait >= aw_delay);
        axi_if.wready  = w_toggle ? wready_ph : 1'b1;
        wready_ph      = ~wready_ph;
        axi_if.bvalid  = b_due;
        axi_if.bresp   = (burst_no == err_burst) ? 2'b10 : 2'b00;
        #1;
        if (axi_if.awvalid && !axi_if.awready) aw_wait++;
        else aw_wait = 0;
        if (axi_if.wvalid && axi_if.wready && axi_if.wlast) b_due = 1'b1;
        if (axi_if.bvalid && axi_if.bready) begin
          b_due = 1'b0;
          burst_no++;
        end
      end
    end
  end

  // Monitor: checks AW and W handshakes against the expected queues.
  initial begin
    forever begin
      @(negedge ACLK);
      #2;
      if (!ARESETN) begin
        holding = 1'b0; aw_done = 1'b0; beat = 0;
      end else begin
        if (axi_if.awvalid) begin
          if (holding) begin
            chk("aw_addr_stable", axi_if.awaddr, hold_addr);
            chk("aw_len_stable", 32'(axi_if.awlen), 32'(hold_len));
          end
          hold_addr = axi_if.awaddr;
          hold_len  = axi_if.awlen;
          holding   = !axi_if.awready;
          if (axi_if.awready) begin
            if (q_aw_addr.size() == 0) begin
              n_checks++;
              $display("FAIL aw_unexpected: got awaddr %h want no burst", axi_if.awaddr);
            end else begin
              e_addr = q_aw_addr.pop_front();
              e_len  = q_aw_len.pop_front();
              chk("awaddr", axi_if.awaddr, e_addr);
              chk("awlen", 32'(axi_if.awlen), 32'(e_len));
              chk("aw_fixed", 32'({axi_if.awsize, axi_if.awburst, axi_if.awcache, axi_if.awprot,
                                   axi_if.awqos, axi_if.awlock, axi_if.awid}),
                  32'({3'b010, 2'b01, 4'b0011, 3'b000, 4'b0000, 2'b00, 6'd0}));
              cur_len = e_len;
              aw_done = 1'b1;
              beat    = 0;
            end
          end
        end else begin
          holding = 1'b0;
        end
        if (axi_if.wvalid) begin
          chk("w_after_aw", 32'(aw_done), 32'd1);
          if (axi_if.wready) begin
            if (q_w.size() == 0) begin
              n_checks++;
              $display("FAIL w_unexpected: got wdata %h want no beat", axi_if.wdata);
            end else begin
              e_data = q_w.pop_front();
              chk("wdata", axi_if.wdata, e_data);
            end
            chk("wlast", 32'(axi_if.wlast), 32'(beat == int'(cur_len)));
            chk("w_fixed", 32'({axi_if.wstrb, axi_if.wid}), 32'({4'hF, 6'd0}));
            if (beat == int'(cur_len)) aw_done = 1'b0;
            beat++;
          end
        end
      end
    end
  end

  task automatic expect_aw(input logic [31:0] addr, input logic [3:0] len);
    q_aw_addr.push_back(addr);
    q_aw_len.push_back(len);
  endtask

  task automatic push_word(input logic [31:0] d);
    int t = 0;
    @(negedge ACLK);
    s_valid = 1'b1;
    s_data  = d;
    #2;
    while (!s_ready && t < 2000) begin
      @(negedge ACLK);
      #2;
      t++;
    end
    if (!s_ready) begin
      n_checks++;
      $display("FAIL push_timeout: s_ready=0 want 1 for word %h", d);
      s_valid = 1'b0;
    end else begin
      q_w.push_back(d);
      @(posedge ACLK);
      #1;
      s_valid = 1'b0;
    end
  endtask

  task automatic push_n(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) push_word(base + 32'(i));
  endtask

  task automatic wait_done(input logic [31:0] exp_ptr);
    int t = 0;
    while (!(wr_ptr == exp_ptr && !busy) && t < 3000) begin
      @(negedge ACLK);
      t++;
    end
    chk("drain_wr_ptr", wr_ptr, exp_ptr);
    chk("aw_queue_empty", 32'(q_aw_addr.size()), 32'd0);
    chk("w_queue_empty", 32'(q_w.size()), 32'd0);
  endtask

  task automatic do_reset();
    q_aw_addr.delete();
    q_aw_len.delete();
    q_w.delete();
    ARESETN   = 1'b0;
    enable    = 1'b0;
    s_valid   = 1'b0;
    aw_delay  = 0;
    w_toggle  = 1'b0;
    err_burst = -1;
    repeat (2) @(negedge ACLK);
    chk("rst_outputs", 32'({axi_if.awvalid, axi_if.wvalid, axi_if.bready, axi_if.wlast, busy, err}), 32'd0);
    chk("rst_wr_ptr", wr_ptr, 32'd0);
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    ARESETN = 1'b1;
    @(posedge ACLK);
    #1;
    chk("s_ready_after_rst", 32'(s_ready), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time %0t exceeded", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: two aligned bursts, plus AW launch latency after fill reaches 16
    do_reset();
    enable = 1'b1;
    expect_aw(BASE, 4'd15);
    expect_aw(BASE + 32'h40, 4'd15);
    push_n(16, 32'h0);
    @(negedge ACLK);
    chk("aw_latency_pre", 32'(axi_if.awvalid), 32'd0);
    @(negedge ACLK);
    chk("aw_latency_post", 32'(axi_if.awvalid), 32'd1);
    push_n(16, 32'd16);
    wait_done(32'd32);
    chk("t1_err", 32'(err), 32'd0);

    // 2: ring wrap on the fifth burst
    do_reset();
    enable = 1'b1;
    expect_aw(BASE, 4'd15);
    expect_aw(BASE + 32'h40, 4'd15);
    expect_aw(BASE + 32'h80, 4'd15);
    expect_aw(BASE + 32'hC0, 4'd15);
    expect_aw(BASE, 4'd15);
    push_n(80, 32'h100);
    wait_done(32'd80);

    // 3: slow awready and toggling wready
    do_reset();
    aw_delay = 10;
    w_toggle = 1'b1;
    enable   = 1'b1;
    expect_aw(BASE, 4'd15);
    push_n(16, 32'hA000_0000);
    wait_done(32'd16);

    // 4: error response on the second burst is sticky
    do_reset();
    err_burst = 1;
    enable    = 1'b1;
    expect_aw(BASE, 4'd15);
    expect_aw(BASE + 32'h40, 4'd15);
    push_n(32, 32'h200);
    wait_done(32'd32);
    chk("t4_err_set", 32'(err), 32'd1);
    expect_aw(BASE + 32'h80, 4'd15);
    push_n(16, 32'h300);
    wait_done(32'd48);
    chk("t4_err_sticky", 32'(err), 32'd1);

    // 5: fill the FIFO while disabled, then release
    do_reset();
    push_n(64, 32'h500);
    @(negedge ACLK);
    s_valid = 1'b1;
    s_data  = 32'hDEAD_BEEF;
    #2;
    chk("t5_full_backpressure", 32'(s_ready), 32'd0);
    chk("t5_idle_while_disabled", 32'({busy, axi_if.awvalid}), 32'd0);
    @(negedge ACLK);
    s_valid = 1'b0;
    expect_aw(BASE, 4'd15);
    expect_aw(BASE + 32'h40, 4'd15);
    expect_aw(BASE + 32'h80, 4'd15);
    expect_aw(BASE + 32'hC0, 4'd15);
    enable = 1'b1;
    wait_done(32'd64);

`ifdef HP0_WR_FLUSH_EN
    // 6a: partial burst by flush, then realignment to the 64 B window
    do_reset();
    enable = 1'b1;
    expect_aw(BASE, 4'd4);
    push_n(5, 32'h700);
    @(negedge ACLK);
    flush = 1'b1;
    @(negedge ACLK);
    flush = 1'b0;
    wait_done(32'd5);
    expect_aw(BASE + 32'h14, 4'd10);
    push_n(16, 32'h800);
    wait_done(32'd16);
    expect_aw(BASE + 32'h40, 4'd4);
    @(negedge ACLK);
    flush = 1'b1;
    @(negedge ACLK);
    flush = 1'b0;
    wait_done(32'd21);
`endif

    // 6b: asynchronous reset in the middle of a data phase
    do_reset();
    w_toggle = 1'b1;
    enable   = 1'b1;
    expect_aw(BASE, 4'd15);
    push_n(16, 32'h900);
    begin
      int t = 0;
      while (!axi_if.wvalid && t < 200) begin
        @(negedge ACLK);
        t++;
      end
      chk("t6_reached_data", 32'(axi_if.wvalid), 32'd1);
    end
    #3;
    ARESETN = 1'b0;
    q_aw_addr.delete();
    q_aw_len.delete();
    q_w.delete();
    #1;
    chk("t6_async_abort", 32'({axi_if.awvalid, axi_if.wvalid, axi_if.bready, busy}), 32'd0);
    repeat (2) @(negedge ACLK);
    ARESETN = 1'b1;
    repeat (6) @(negedge ACLK);
    chk("t6_quiet_after", 32'({busy, axi_if.awvalid, axi_if.wvalid}), 32'd0);
    chk("t6_wr_ptr", wr_ptr, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
